// File: rtl/glyph_loader.sv
// Character-design RAM writer: assembles 10 row bytes per glyph
// and strobes one 80-bit write per glyph, bursting to index+1.
module glyph_loader #(
  parameter int INDEX_WIDTH = 8,
  parameter int CHARS       = 256
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [7:0]             in_data,
  input  logic                   in_first,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   wr_en,
  output logic [INDEX_WIDTH-1:0] wr_index,
  output logic [79:0]            wr_data,
  output logic                   err
);

  typedef enum logic [1:0] {
    IDLE,
    ROWS,
    WRITE
  } state_t;

  state_t state, state_nx;

  logic [3:0]             count;
  logic [INDEX_WIDTH-1:0] index;
  logic [71:0]            rows;
  logic [31:0]            raw_idx;
  logic [INDEX_WIDTH-1:0] load_idx;
  logic [INDEX_WIDTH-1:0] next_idx;

  logic xfer;
  logic load;
  logic store;
  logic fire;
  logic bad;

  assign raw_idx  = 32'(in_data[INDEX_WIDTH-1:0]);
  assign load_idx = INDEX_WIDTH'(raw_idx % 32'(CHARS));
  assign next_idx = (index == INDEX_WIDTH'(CHARS - 1))
                  ? '0 : index + 1'b1;

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    xfer     = 1'b0;
    load     = 1'b0;
    store    = 1'b0;
    fire     = 1'b0;
    bad      = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        xfer     = in_valid;
        load     = xfer & in_first;
        bad      = xfer & ~in_first;
        if (load) state_nx = ROWS;
      end
      ROWS: begin
        in_ready = 1'b1;
        xfer     = in_valid;
        load     = xfer & in_first;
        store    = xfer & ~in_first;
        fire     = store & (count == 4'd9);
        bad      = load & (count != 4'd0);
        if (fire) state_nx = WRITE;
      end
      WRITE: state_nx = ROWS;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count    <= '0;
      index    <= '0;
      rows     <= '0;
      wr_en    <= 1'b0;
      wr_index <= '0;
      wr_data  <= '0;
      err      <= 1'b0;
    end else begin
      wr_en <= fire;
      err   <= bad;
      if (state == WRITE) begin
        // burst continuation: next 10 rows land on the following slot
        index <= next_idx;
        count <= '0;
      end else if (load) begin
        index <= load_idx;
        count <= '0;
      end else if (fire) begin
        wr_index <= index;
        wr_data  <= {in_data, rows};
        count    <= count + 1'b1;
      end else if (store) begin
        rows[{count[3:0], 3'b000} +: 8] <= in_data;
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_glyph_loader.sv
// Bench for glyph_loader: directed upload scenarios plus random
// traffic against a byte-queue reference model.
module tb_glyph_loader;

  logic        clk;
  logic        reset_n;
  logic [7:0]  in_data;
  logic        in_first;
  logic        in_valid;
  logic        in_ready;
  logic        wr_en;
  logic [7:0]  wr_index;
  logic [79:0] wr_data;
  logic        err;

  glyph_loader #(.INDEX_WIDTH(8), .CHARS(256)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_data  (in_data),
    .in_first (in_first),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .wr_en    (wr_en),
    .wr_index (wr_index),
    .wr_data  (wr_data),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model state
  bit          busy;
  bit          coll;
  int          m_idx;
  logic [7:0]  q[$];
  bit          e_wr_en;
  bit          e_err;
  logic [7:0]  e_wr_index;
  logic [79:0] e_wr_data;

  // observed write/err log
  int          nwr;
  int          nerr;
  logic [7:0]  widx[$];
  logic [79:0] wdat[$];

  task automatic chk(string tag, logic [79:0] got, logic [79:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    busy = 0; coll = 0; m_idx = 0; q = {};
    e_wr_en = 0; e_err = 0; e_wr_index = '0; e_wr_data = '0;
  endtask

  task automatic model_edge(bit v, bit f, logic [7:0] d);
    e_wr_en = 0;
    e_err   = 0;
    if (busy) begin
      busy  = 0;
      m_idx = (m_idx + 1) % 256;
      q     = {};
    end else if (v) begin
      if (f) begin
        if (coll && q.size() != 0) e_err = 1;
        coll  = 1;
        m_idx = int'(d) % 256;
        q     = {};
      end else if (!coll) begin
        e_err = 1;
      end else begin
        q.push_back(d);
        if (q.size() == 10) begin
          e_wr_en    = 1;
          e_wr_index = 8'(m_idx);
          for (int k = 0; k < 10; k++) e_wr_data[8*k +: 8] = q[k];
          busy = 1;
          q    = {};
        end
      end
    end
  endtask

  task automatic step(bit rn, bit v, bit f, logic [7:0] d);
    reset_n  = rn;
    in_valid = v;
    in_first = f;
    in_data  = d;
    if (!rn) model_reset();
    else     model_edge(v, f, d);
    @(negedge clk);
    chk("in_ready", 80'(in_ready), 80'(!busy));
    chk("wr_en",    80'(wr_en),    80'(e_wr_en));
    chk("err",      80'(err),      80'(e_err));
    chk("wr_index", 80'(wr_index), 80'(e_wr_index));
    chk("wr_data",  wr_data,       e_wr_data);
    if (wr_en) begin
      nwr++;
      widx.push_back(wr_index);
      wdat.push_back(wr_data);
    end
    if (err) nerr++;
  endtask

  task automatic clr();
    nwr = 0; nerr = 0; widx = {}; wdat = {};
  endtask

  // present a byte until the model says it was taken
  task automatic send(bit f, logic [7:0] d);
    bit acc;
    int tries;
    tries = 0;
    do begin
      acc = !busy;
      step(1, 1, f, d);
      tries++;
    end while (!acc && tries < 4);
    if (!acc) chk("send_timeout", 80'(0), 80'(1));
  endtask

  task automatic do_reset();
    step(0, 0, 0, 8'h00);
    step(0, 0, 0, 8'h00);
    clr();
  endtask

  initial begin
    reset_n = 0; in_valid = 0; in_first = 0; in_data = '0;
    model_reset();
    clr();

    // single glyph
    do_reset();
    chk("rst_wr_en",  80'(wr_en),    80'(0));
    chk("rst_index",  80'(wr_index), 80'(0));
    chk("rst_data",   wr_data,       80'(0));
    chk("rst_ready",  80'(in_ready), 80'(1));
    send(1, 8'h41);
    for (int r = 1; r <= 10; r++) send(0, 8'(r));
    step(1, 0, 0, 8'h00);
    chk("t1_nwr",  80'(nwr),  80'(1));
    chk("t1_idx",  80'(widx[0]), 80'(8'h41));
    chk("t1_data", wdat[0], 80'h0A090807060504030201);
    chk("t1_nerr", 80'(nerr), 80'(0));

    // burst of two glyphs
    do_reset();
    send(1, 8'h10);
    for (int r = 0; r < 20; r++) send(0, 8'($urandom));
    step(1, 0, 0, 8'h00);
    chk("t2_nwr",  80'(nwr), 80'(2));
    chk("t2_idx0", 80'(widx[0]), 80'(8'h10));
    chk("t2_idx1", 80'(widx[1]), 80'(8'h11));

    // index wrap
    do_reset();
    send(1, 8'hFF);
    for (int r = 0; r < 20; r++) send(0, 8'($urandom));
    step(1, 0, 0, 8'h00);
    chk("t3_nwr",  80'(nwr), 80'(2));
    chk("t3_idx0", 80'(widx[0]), 80'(8'hFF));
    chk("t3_idx1", 80'(widx[1]), 80'(8'h00));

    // abort partial glyph
    do_reset();
    send(1, 8'h20);
    for (int r = 0; r < 4; r++) send(0, 8'(r + 7));
    send(1, 8'h30);
    for (int r = 0; r < 10; r++) send(0, 8'hFF);
    step(1, 0, 0, 8'h00);
    chk("t4_nerr", 80'(nerr), 80'(1));
    chk("t4_nwr",  80'(nwr),  80'(1));
    chk("t4_idx",  80'(widx[0]), 80'(8'h30));
    chk("t4_data", wdat[0], {80{1'b1}});

    // orphan byte then a normal upload
    do_reset();
    send(0, 8'h55);
    step(1, 0, 0, 8'h00);
    chk("t5_nerr", 80'(nerr), 80'(1));
    chk("t5_nwr0", 80'(nwr),  80'(0));
    send(1, 8'h41);
    for (int r = 1; r <= 10; r++) send(0, 8'(r));
    step(1, 0, 0, 8'h00);
    chk("t5_nwr1", 80'(nwr), 80'(1));
    chk("t5_idx",  80'(widx[0]), 80'(8'h41));

    // reset in the middle of a glyph
    do_reset();
    send(1, 8'h05);
    for (int r = 0; r < 6; r++) send(0, 8'(r + 1));
    step(0, 0, 0, 8'h00);
    chk("t6_rst_idx",  80'(wr_index), 80'(0));
    chk("t6_rst_data", wr_data,       80'(0));
    clr();
    for (int r = 0; r < 4; r++) send(0, 8'(r + 1));
    step(1, 0, 0, 8'h00);
    chk("t6_nerr", 80'(nerr), 80'(4));
    chk("t6_nwr",  80'(nwr),  80'(0));

    // random traffic
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      bit rn, v, f;
      rn = ($urandom_range(0, 599) != 0);
      v  = ($urandom_range(0, 3) != 0);
      f  = ($urandom_range(0, 13) == 0);
      step(rn, v, f, 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
